// File: rtl/spu_issue_pkg.sv
// Shared types, unit codes and result latencies for the SPU issue stage.
package spu_issue_pkg;

   localparam int SB_ENTRIES = 128;
   localparam int NUM_SRC    = 6;

   typedef enum logic {PIPE_EVEN = 1'b0, PIPE_ODD = 1'b1} pipe_t;

   typedef enum logic [1:0] {ST_EMPTY, ST_PAIR, ST_SECOND} state_t;

   localparam logic [1:0] UNIT_FP   = 2'd0;
   localparam logic [1:0] UNIT_FX2  = 2'd1;
   localparam logic [1:0] UNIT_BYTE = 2'd2;
   localparam logic [1:0] UNIT_FX1  = 2'd3;
   localparam logic [1:0] UNIT_PERM = 2'd0;
   localparam logic [1:0] UNIT_LS   = 2'd1;
   localparam logic [1:0] UNIT_BR   = 2'd2;
   localparam logic [1:0] UNIT_NONE = 2'd3;

   typedef struct packed {
      logic [31:0]     instr;
      logic            pipe;
      logic [1:0]      unit;
      logic [6:0]      rt;
      logic            wr;
      logic [2:0][6:0] src;
      logic [2:0]      src_use;
   } slot_t;

   // Cycles until a unit's result may be read by a dependent instruction.
   function automatic logic [2:0] unit_latency(input logic pipe, input logic [1:0] unit);
      logic [2:0] lat;
      lat = 3'd0;
      if (pipe == PIPE_EVEN) begin
         case (unit)
            UNIT_FP:   lat = 3'd6;
            UNIT_FX2:  lat = 3'd4;
            UNIT_BYTE: lat = 3'd4;
            UNIT_FX1:  lat = 3'd2;
         endcase
      end else begin
         case (unit)
            UNIT_PERM: lat = 3'd4;
            UNIT_LS:   lat = 3'd6;
            UNIT_BR:   lat = 3'd1;
            UNIT_NONE: lat = 3'd0;
         endcase
      end
      return lat;
   endfunction

   function automatic logic [2:0] max3(input logic [2:0] a, input logic [2:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register-readiness scoreboard: one 3-bit countdown per architectural register.
module issue_scoreboard
   import spu_issue_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [1:0]                set_en,
   input  logic [1:0][6:0]           set_addr,
   input  logic [1:0][2:0]           set_lat,
   input  logic [NUM_SRC-1:0][6:0]   src_addr,
   input  logic [NUM_SRC-1:0]        src_use,
   output logic [NUM_SRC-1:0]        src_ready
);

   logic [2:0] cnt      [SB_ENTRIES];
   logic [2:0] cnt_next [SB_ENTRIES];
   logic [2:0] load0, load1;

   // A load never shortens a pending countdown; when both slots target the
   // same register the longer of the two results governs.
   always_comb begin
      for (int i = 0; i < SB_ENTRIES; i++) begin
         cnt_next[i] = (cnt[i] != 3'd0) ? cnt[i] - 3'd1 : 3'd0;
      end
      load0 = max3(cnt[set_addr[0]], set_lat[0]);
      load1 = (set_en[0] && set_addr[0] == set_addr[1]) ? max3(load0, set_lat[1])
                                                        : max3(cnt[set_addr[1]], set_lat[1]);
      if (set_en[0]) cnt_next[set_addr[0]] = load0;
      if (set_en[1]) cnt_next[set_addr[1]] = load1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SB_ENTRIES; i++) cnt[i] <= 3'd0;
      end else begin
         for (int i = 0; i < SB_ENTRIES; i++) cnt[i] <= cnt_next[i];
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_SRC; k++) begin
         src_ready[k] = !src_use[k] || (cnt[src_addr[k]] == 3'd0);
      end
   end

endmodule

// File: rtl/issue_stage.sv
// SPU in-order dual-pipe issue stage with a one-pair buffer and scoreboard.
// Dual issue of a pair is enabled only when ISSUE_DUAL_EN is defined.
module issue_stage
   import spu_issue_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0][31:0]      in_instr,
   input  logic [7:0]            in_pc,
   input  logic [1:0]            in_pipe,
   input  logic [1:0][1:0]       in_unit,
   input  logic [1:0][6:0]       in_rt,
   input  logic [1:0]            in_wr,
   input  logic [1:0][2:0][6:0]  in_src,
   input  logic [1:0][2:0]       in_src_use,
   input  logic                  flush,
   output logic                  out_even_valid,
   output logic                  out_odd_valid,
   output logic [31:0]           out_even_instr,
   output logic [31:0]           out_odd_instr,
   output logic                  out_first_odd,
   output logic [7:0]            out_pc
);

   state_t                   state;
   slot_t [1:0]              hold_slot;
   slot_t [1:0]              in_slot;
   logic [7:0]               hold_pc;
   logic [NUM_SRC-1:0][6:0]  src_addr;
   logic [NUM_SRC-1:0]       src_use;
   logic [NUM_SRC-1:0]       src_ready;
   logic [1:0]               slot_ready;
   logic [1:0]               set_en;
   logic [1:0][6:0]          set_addr;
   logic [1:0][2:0]          set_lat;
   logic                     raw_hazard, dual_ok, issue0, issue1, accept;
   logic                     even_valid_n, odd_valid_n, first_odd_n;
   logic [31:0]              even_instr_n, odd_instr_n;

   always_comb begin
      raw_hazard = 1'b0;
      for (int s = 0; s < 2; s++) begin
         in_slot[s].instr   = in_instr[s];
         in_slot[s].pipe    = in_pipe[s];
         in_slot[s].unit    = in_unit[s];
         in_slot[s].rt      = in_rt[s];
         in_slot[s].wr      = in_wr[s];
         in_slot[s].src     = in_src[s];
         in_slot[s].src_use = in_src_use[s];
         for (int k = 0; k < 3; k++) begin
            src_addr[s*3+k] = hold_slot[s].src[k];
            src_use[s*3+k]  = hold_slot[s].src_use[k];
         end
      end
      for (int k = 0; k < 3; k++) begin
         raw_hazard = raw_hazard | (hold_slot[0].wr && hold_slot[1].src_use[k] &&
                                    hold_slot[1].src[k] == hold_slot[0].rt);
      end
   end

   assign slot_ready[0] = &src_ready[2:0];
   assign slot_ready[1] = &src_ready[5:3];

`ifdef ISSUE_DUAL_EN
   assign dual_ok = (hold_slot[0].pipe != hold_slot[1].pipe) && (&slot_ready) && !raw_hazard;
`else
   assign dual_ok = 1'b0;
`endif

   // Slot 1 only ever issues when nothing older remains, so issue1 also
   // means the buffer drains this cycle and may take the next pair.
   assign issue0   = !flush && (state == ST_PAIR) && (dual_ok || slot_ready[0]);
   assign issue1   = !flush && (((state == ST_PAIR) && dual_ok) ||
                                ((state == ST_SECOND) && slot_ready[1]));
   assign in_ready = reset && !flush && ((state == ST_EMPTY) || issue1);
   assign accept   = in_valid && in_ready;

   always_comb begin
      even_valid_n = 1'b0;
      odd_valid_n  = 1'b0;
      even_instr_n = 32'd0;
      odd_instr_n  = 32'd0;
      if (issue0) begin
         if (hold_slot[0].pipe == PIPE_ODD) begin
            odd_valid_n = 1'b1;
            odd_instr_n = hold_slot[0].instr;
         end else begin
            even_valid_n = 1'b1;
            even_instr_n = hold_slot[0].instr;
         end
      end
      if (issue1) begin
         if (hold_slot[1].pipe == PIPE_ODD) begin
            odd_valid_n = 1'b1;
            odd_instr_n = hold_slot[1].instr;
         end else begin
            even_valid_n = 1'b1;
            even_instr_n = hold_slot[1].instr;
         end
      end
      first_odd_n = odd_valid_n && (!even_valid_n || hold_slot[0].pipe == PIPE_ODD);
   end

   assign set_en[0]   = issue0 && hold_slot[0].wr;
   assign set_en[1]   = issue1 && hold_slot[1].wr;
   assign set_addr[0] = hold_slot[0].rt;
   assign set_addr[1] = hold_slot[1].rt;
   assign set_lat[0]  = unit_latency(hold_slot[0].pipe, hold_slot[0].unit);
   assign set_lat[1]  = unit_latency(hold_slot[1].pipe, hold_slot[1].unit);

   issue_scoreboard u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .set_en    (set_en),
      .set_addr  (set_addr),
      .set_lat   (set_lat),
      .src_addr  (src_addr),
      .src_use   (src_use),
      .src_ready (src_ready)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_EMPTY;
         hold_slot      <= '0;
         hold_pc        <= 8'd0;
         out_even_valid <= 1'b0;
         out_odd_valid  <= 1'b0;
         out_even_instr <= 32'd0;
         out_odd_instr  <= 32'd0;
         out_first_odd  <= 1'b0;
         out_pc         <= 8'd0;
      end else begin
         out_even_valid <= even_valid_n;
         out_odd_valid  <= odd_valid_n;
         out_even_instr <= even_instr_n;
         out_odd_instr  <= odd_instr_n;
         out_first_odd  <= first_odd_n;
         out_pc         <= (issue0 || issue1) ? hold_pc : 8'd0;
         if (flush) begin
            state <= ST_EMPTY;
         end else if (accept) begin
            state     <= ST_PAIR;
            hold_slot <= in_slot;
            hold_pc   <= in_pc;
         end else if (issue1) begin
            state <= ST_EMPTY;
         end else if (issue0) begin
            state <= ST_SECOND;
         end
      end
   end

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: directed scenarios then random pairs, checked against a
// queue-of-pending-instructions model with a per-register ready-time table.
module tb_issue_stage;

   typedef struct packed {
      logic [31:0]     instr;
      logic            pipe;
      logic [1:0]      unit;
      logic [6:0]      rt;
      logic            wr;
      logic [2:0][6:0] src;
      logic [2:0]      src_use;
   } tb_slot_t;

`ifdef ISSUE_DUAL_EN
   localparam bit DUAL_EN = 1'b1;
`else
   localparam bit DUAL_EN = 1'b0;
`endif

   logic                 clk;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [1:0][31:0]     in_instr;
   logic [7:0]           in_pc;
   logic [1:0]           in_pipe;
   logic [1:0][1:0]      in_unit;
   logic [1:0][6:0]      in_rt;
   logic [1:0]           in_wr;
   logic [1:0][2:0][6:0] in_src;
   logic [1:0][2:0]      in_src_use;
   logic                 flush;
   logic                 out_even_valid, out_odd_valid, out_first_odd;
   logic [31:0]          out_even_instr, out_odd_instr;
   logic [7:0]           out_pc;

   int checks   = 0;
   int failures = 0;

   int        sb [128];
   tb_slot_t  pend[$];
   logic [7:0] model_pc;
   logic       exp_even_valid, exp_odd_valid, exp_first_odd;
   logic [31:0] exp_even_instr, exp_odd_instr;
   logic [7:0] exp_pc;

   issue_stage dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_instr       (in_instr),
      .in_pc          (in_pc),
      .in_pipe        (in_pipe),
      .in_unit        (in_unit),
      .in_rt          (in_rt),
      .in_wr          (in_wr),
      .in_src         (in_src),
      .in_src_use     (in_src_use),
      .flush          (flush),
      .out_even_valid (out_even_valid),
      .out_odd_valid  (out_odd_valid),
      .out_even_instr (out_even_instr),
      .out_odd_instr  (out_odd_instr),
      .out_first_odd  (out_first_odd),
      .out_pc         (out_pc)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int latency_of(tb_slot_t s);
      if (s.pipe == 1'b0) begin
         case (s.unit)
            2'd0:    return 6;
            2'd1:    return 4;
            2'd2:    return 4;
            default: return 2;
         endcase
      end
      case (s.unit)
         2'd0:    return 4;
         2'd1:    return 6;
         2'd2:    return 1;
         default: return 0;
      endcase
   endfunction

   function automatic bit sources_free(tb_slot_t s);
      for (int k = 0; k < 3; k++) begin
         if (s.src_use[k] && sb[s.src[k]] != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit reads_result(tb_slot_t later, tb_slot_t earlier);
      if (!earlier.wr) return 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (later.src_use[k] && later.src[k] == earlier.rt) return 1'b1;
      end
      return 1'b0;
   endfunction

   // How many of the oldest pending instructions leave this cycle.
   function automatic int issue_count(bit fl);
      if (fl || pend.size() == 0) return 0;
      if (pend.size() == 2 && DUAL_EN && pend[0].pipe != pend[1].pipe &&
          sources_free(pend[0]) && sources_free(pend[1]) && !reads_result(pend[1], pend[0]))
         return 2;
      return sources_free(pend[0]) ? 1 : 0;
   endfunction

   task automatic model_commit(input int n, input bit take, input tb_slot_t s0,
                               input tb_slot_t s1, input logic [7:0] pc, input bit fl);
      int ld [128];
      int r, m, lat;
      for (int i = 0; i < 128; i++) ld[i] = -1;
      exp_even_valid = 1'b0; exp_odd_valid = 1'b0; exp_first_odd = 1'b0;
      exp_even_instr = 32'd0; exp_odd_instr = 32'd0; exp_pc = 8'd0;
      for (int k = 0; k < n; k++) begin
         if (pend[k].pipe) begin
            exp_odd_valid = 1'b1;
            exp_odd_instr = pend[k].instr;
         end else begin
            exp_even_valid = 1'b1;
            exp_even_instr = pend[k].instr;
         end
         if (pend[k].wr) begin
            r   = int'(pend[k].rt);
            lat = latency_of(pend[k]);
            m   = (ld[r] > sb[r]) ? ld[r] : sb[r];
            ld[r] = (m > lat) ? m : lat;
         end
      end
      if (n > 0) begin
         exp_first_odd = pend[0].pipe;
         exp_pc        = model_pc;
      end
      for (int i = 0; i < 128; i++) sb[i] = (ld[i] >= 0) ? ld[i] : ((sb[i] > 0) ? sb[i] - 1 : 0);
      for (int k = 0; k < n; k++) pend.delete(0);
      if (fl) pend.delete();
      if (take) begin
         pend.delete();
         pend.push_back(s0);
         pend.push_back(s1);
         model_pc = pc;
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 128; i++) sb[i] = 0;
      pend.delete();
      model_pc = 8'd0;
   endtask

   task automatic applyStimulus(input bit v, input tb_slot_t s0, input tb_slot_t s1,
                                input logic [7:0] pc, input bit fl);
      int n;
      bit ready_exp;
      in_valid      = v;
      flush         = fl;
      in_pc         = pc;
      in_instr[0]   = s0.instr;   in_instr[1]   = s1.instr;
      in_pipe       = {s1.pipe, s0.pipe};
      in_unit[0]    = s0.unit;    in_unit[1]    = s1.unit;
      in_rt[0]      = s0.rt;      in_rt[1]      = s1.rt;
      in_wr         = {s1.wr, s0.wr};
      in_src[0]     = s0.src;     in_src[1]     = s1.src;
      in_src_use[0] = s0.src_use; in_src_use[1] = s1.src_use;
      @(negedge clk);
      n = issue_count(fl);
      ready_exp = !fl && (pend.size() == n);
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, ready_exp});
      @(posedge clk);
      #1;
      model_commit(n, v && ready_exp, s0, s1, pc, fl);
      checkOutput("even_valid", {31'd0, out_even_valid}, {31'd0, exp_even_valid});
      checkOutput("odd_valid",  {31'd0, out_odd_valid},  {31'd0, exp_odd_valid});
      checkOutput("even_instr", out_even_instr, exp_even_instr);
      checkOutput("odd_instr",  out_odd_instr,  exp_odd_instr);
      checkOutput("first_odd",  {31'd0, out_first_odd}, {31'd0, exp_first_odd});
      checkOutput("out_pc",     {24'd0, out_pc}, {24'd0, exp_pc});
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) applyStimulus(1'b0, '0, '0, 8'h00, 1'b0);
   endtask

   function automatic tb_slot_t mk(input bit pipe, input int unit, input int rt, input bit wr,
                                   input int ra, input bit ra_use);
      tb_slot_t s;
      s            = '0;
      s.instr      = $urandom;
      s.pipe       = pipe;
      s.unit       = 2'(unit);
      s.rt         = 7'(rt);
      s.wr         = wr;
      s.src[0]     = 7'(ra);
      s.src_use[0] = ra_use;
      return s;
   endfunction

   function automatic tb_slot_t rand_slot();
      tb_slot_t s;
      s.instr = $urandom;
      s.pipe  = 1'($urandom_range(0, 1));
      s.unit  = s.pipe ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
      s.rt    = 7'($urandom_range(0, 7));
      s.wr    = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) begin
         s.src[k]     = 7'($urandom_range(0, 7));
         s.src_use[k] = 1'($urandom_range(0, 1));
      end
      return s;
   endfunction

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_in_ready"},   {31'd0, in_ready},       32'd0);
      checkOutput({tag, "_even_valid"}, {31'd0, out_even_valid}, 32'd0);
      checkOutput({tag, "_odd_valid"},  {31'd0, out_odd_valid},  32'd0);
      checkOutput({tag, "_even_instr"}, out_even_instr,          32'd0);
      checkOutput({tag, "_odd_instr"},  out_odd_instr,           32'd0);
      checkOutput({tag, "_first_odd"},  {31'd0, out_first_odd},  32'd0);
      checkOutput({tag, "_pc"},         {24'd0, out_pc},         32'd0);
   endtask

   initial begin
      clk = 1'b0; reset = 1'b0; in_valid = 1'b0; flush = 1'b0; in_pc = 8'd0;
      in_instr = '0; in_pipe = '0; in_unit = '0; in_rt = '0; in_wr = '0;
      in_src = '0; in_src_use = '0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b1;

      // Independent FX1 even + LS odd with a clean scoreboard.
      applyStimulus(1'b1, mk(1'b0, 3, 1, 1'b1, 10, 1'b1), mk(1'b1, 1, 2, 1'b1, 11, 1'b1), 8'h10, 1'b0);
      idle(3);

      // FP writes r5; the following pair reads r5 and must wait it out.
      applyStimulus(1'b1, mk(1'b0, 0, 5, 1'b1, 0, 1'b0), mk(1'b1, 2, 21, 1'b0, 0, 1'b0), 8'h20, 1'b0);
      idle(2);
      applyStimulus(1'b1, mk(1'b0, 3, 12, 1'b1, 5, 1'b1), mk(1'b1, 1, 13, 1'b1, 0, 1'b0), 8'h24, 1'b0);
      idle(9);

      // Two even instructions in one pair.
      applyStimulus(1'b1, mk(1'b0, 3, 30, 1'b1, 0, 1'b0), mk(1'b0, 1, 31, 1'b1, 0, 1'b0), 8'h30, 1'b0);
      idle(3);

      // Slot 1 reads the FX1 result of slot 0.
      applyStimulus(1'b1, mk(1'b0, 3, 9, 1'b1, 0, 1'b0), mk(1'b1, 1, 14, 1'b1, 9, 1'b1), 8'h40, 1'b0);
      idle(5);

      // Flush while slot 1 is still waiting, then a fresh pair.
      applyStimulus(1'b1, mk(1'b0, 3, 9, 1'b1, 0, 1'b0), mk(1'b1, 0, 15, 1'b1, 9, 1'b1), 8'h50, 1'b0);
      idle(1);
      applyStimulus(1'b1, mk(1'b0, 1, 16, 1'b1, 0, 1'b0), mk(1'b1, 1, 17, 1'b1, 0, 1'b0), 8'h54, 1'b1);
      applyStimulus(1'b1, mk(1'b0, 1, 16, 1'b1, 0, 1'b0), mk(1'b1, 1, 17, 1'b1, 0, 1'b0), 8'h58, 1'b0);
      idle(3);

      // Reset pulse while slot 1 stalls on r5, right after slot 0 issued.
      applyStimulus(1'b1, mk(1'b0, 0, 5, 1'b1, 0, 1'b0), mk(1'b1, 2, 22, 1'b0, 0, 1'b0), 8'h60, 1'b0);
      idle(2);
      applyStimulus(1'b1, mk(1'b1, 1, 23, 1'b1, 0, 1'b0), mk(1'b0, 3, 24, 1'b1, 5, 1'b1), 8'h64, 1'b0);
      idle(1);
      #1;
      reset = 1'b0;
      #1;
      check_all_zero("midreset");
      reset_model();
      #1;
      reset = 1'b1;
      applyStimulus(1'b1, mk(1'b0, 3, 25, 1'b1, 5, 1'b1), mk(1'b1, 1, 26, 1'b1, 0, 1'b0), 8'h70, 1'b0);
      idle(3);

      for (int c = 0; c < 400; c++) begin
         applyStimulus(1'($urandom_range(0, 9) < 7), rand_slot(), rand_slot(), 8'($urandom),
                       1'($urandom_range(0, 19) == 0));
      end
      idle(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/issue_stage.md
ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state rising-edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have port: in_valid  input  1  decoder presents an instruction pair.
REQ-004 SHALL have port: in_ready  output  1  stage accepts the pair this cycle.
REQ-005 SHALL have port: in_instr  input  2x32  instruction words; slot 0 first in program order.
REQ-006 SHALL have port: in_pc  input  8  PC of slot 0.
REQ-007 SHALL have port: in_pipe  input  2  per slot: 0 even, 1 odd.
REQ-008 SHALL have port: in_unit  input  2x2  per slot unit code (even: FP,FX2,Byte,FX1; odd: Perm,LS,Br,-).
REQ-009 SHALL have port: in_rt  input  2x7  per slot destination address.
REQ-010 SHALL have port: in_wr  input  2  per slot: writes rt.
REQ-011 SHALL have port: in_src  input  2x3x7  per slot ra/rb/rc addresses.
REQ-012 SHALL have port: in_src_use  input  2x3  per slot source-valid bits.
REQ-013 SHALL have port: flush  input  1  branch taken; discard held instructions.
REQ-014 SHALL have port: out_even_valid, out_odd_valid  output  1 each  issue to even/odd pipe.
REQ-015 SHALL have port: out_even_instr, out_odd_instr  output  32 each  issued words (0 when not valid).
REQ-016 SHALL have port: out_first_odd  output  1  odd issued instruction is earlier in program order.
REQ-017 SHALL have port: out_pc  output  8  PC of issued pair.

Function
REQ-018 SHALL hold one accepted pair in a buffer with states EMPTY, PAIR (both slots pending), SECOND (slot 1 pending).
REQ-019 SHALL keep a 128-entry scoreboard of 3-bit countdowns; a source is ready when its counter is 0 or its src_use bit is 0.
REQ-020 SHALL, on issue with in_wr, load counter[rt] with max(current, latency[pipe][unit]); latencies FP 6, FX2 4, Byte 4, FX1 2, Perm 4, LS 6, Br 1.
REQ-021 SHALL decrement every nonzero counter by 1 each cycle; a same-cycle load on that entry wins.
REQ-022 SHALL in PAIR dual-issue both slots when: pipes differ, all sources of both ready, and slot 1 reads no rt written by slot 0; state -> EMPTY.
REQ-023 SHALL otherwise in PAIR issue slot 0 alone if its sources are ready (state -> SECOND), else issue nothing.
REQ-024 SHALL in SECOND issue slot 1 when its sources are ready; state -> EMPTY.
REQ-025 SHALL drive in_ready = 1 when EMPTY, or when the buffer's whole remaining content issues this cycle; pair accepted on in_valid & in_ready -> PAIR.
REQ-026 SHALL register outputs: issue decision made from buffer, outputs valid the following cycle (1-cycle latency buffer-to-out).
REQ-027 SHALL on flush: clear buffer to EMPTY, suppress this cycle's issue and acceptance, leave scoreboard unchanged; flush wins over all events.
REQ-028 SHALL set out_first_odd = 1 only when the issued odd instruction is slot 0 and the even one is slot 1, or odd issues alone.

Reset
REQ-029 SHALL on reset = 0 asynchronously: state EMPTY, all counters 0, all out_* 0, in_ready 0 until reset deasserts.
REQ-030 SHALL drop any held pair when reset asserts mid-operation; no partial issue after release.

Configuration
REQ-031 SHALL with macro ISSUE_DUAL_EN defined behave per REQ-022; without it never dual-issue (PAIR always uses REQ-023 path).

Structure
REQ-032 SHALL place unit codes, pipe enum, state enum and latency table in shared package spu_issue_pkg.
REQ-033 SHALL implement the scoreboard as sub-module issue_scoreboard (128x3 counters, set/decrement/ready lookup).

Verification
REQ-034 SHALL cover: independent FX1 even + LS odd pair, all counters 0 -> both issue next cycle, out_first_odd 0.
REQ-035 SHALL cover: FP writes r5, next pair reads r5 -> stall 6 cycles, issue on cycle counter hits 0.
REQ-036 SHALL cover: two even instrs in one pair -> slot 0 issues, slot 1 issues next cycle, in_ready low for one cycle.
REQ-037 SHALL cover: slot 1 reads slot 0 rt r9 (FX1) -> split issue, slot 1 waits 2 cycles.
REQ-038 SHALL cover: flush while SECOND -> buffer EMPTY, no issue, next pair accepted following cycle.
REQ-039 SHALL cover: reset pulsed low mid-stall -> outputs 0 immediately, counters 0, clean accept after release.
